// File: rtl/dlfloat_result_tx.sv
// dlfloat_result_tx: outbound result transmitter for the DLFloat MAC datapath.
// Buffers 16-bit DLFloat results in a DEPTH-word FIFO and serialises each word
// onto an 8-bit host channel, low byte first, then high byte.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   res_data/valid    result word in; res_ready = FIFO not full
//   tx_byte/valid     byte out to host; tx_ready = host accepts
//   tx_last           high while the high byte is presented
//   tx_oe             bidirectional pad output enable (= tx_valid)
//   fifo_count        words in FIFO, excluding the word being transmitted
//   overflow          sticky drop flag; ovf_clr clears it (set wins)
module dlfloat_result_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              res_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic                     tx_oe,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q;
  logic            push, pop, not_empty;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even when a pop frees a slot at the same edge.
  assign res_ready = (count_q != Full);
  assign push      = res_valid & res_ready;
  assign not_empty = (count_q != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (not_empty) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = StLo;
        end
      end
      StLo: begin
        if (tx_ready) state_d = StHi;
      end
      StHi: begin
        if (tx_ready) begin
          // Reload straight from the FIFO so words stream without a bubble.
          if (not_empty) begin
            pop     = 1'b1;
            hold_d  = mem_q[rd_ptr_q];
            state_d = StLo;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (res_valid && !res_ready) overflow_q <= 1'b1;
      else if (ovf_clr)            overflow_q <= 1'b0;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_data;
  end

  always_comb begin
    tx_byte = 8'h00;
    unique case (state_q)
      StLo:    tx_byte = hold_q[7:0];
      StHi:    tx_byte = hold_q[15:8];
      default: tx_byte = 8'h00;
    endcase
  end

  assign tx_valid   = (state_q != StIdle);
  assign tx_oe      = tx_valid;
  assign tx_last    = (state_q == StHi);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dlfloat_result_tx.sv
module tb_dlfloat_result_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        tx_oe;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_w [8];

  dlfloat_result_tx #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .tx_oe      (tx_oe),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check n words (2n bytes) streaming out with tx_ready held high,
  // starting from the byte currently presented.
  task automatic drain(input int n, input string tag);
    tx_ready = 1'b1;
    for (int k = 0; k < 2 * n; k++) begin
      check({tag, "_valid"}, {15'd0, tx_valid}, 16'd1);
      check({tag, "_byte"}, {8'd0, tx_byte},
            (k % 2 == 0) ? {8'd0, exp_w[k/2][7:0]} : {8'd0, exp_w[k/2][15:8]});
      check({tag, "_last"}, {15'd0, tx_last}, {15'd0, 1'(k % 2)});
      step();
    end
    check({tag, "_idle"}, {15'd0, tx_valid}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b1; res_data = '0; res_valid = 1'b0; tx_ready = 1'b0; ovf_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", {15'd0, res_ready}, 16'd1);
    check("rst_valid", {15'd0, tx_valid}, 16'd0);
    check("rst_byte", {8'd0, tx_byte}, 16'd0);
    check("rst_last", {15'd0, tx_last}, 16'd0);
    check("rst_oe", {15'd0, tx_oe}, 16'd0);
    check("rst_count", {13'd0, fifo_count}, 16'd0);
    check("rst_ovf", {15'd0, overflow}, 16'd0);
    step(); step();
    #2 rst_n = 1'b1;

    // Single word
    tx_ready = 1'b1; res_data = 16'h4A3C; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("single_cnt1", {13'd0, fifo_count}, 16'd1);
    check("single_nv", {15'd0, tx_valid}, 16'd0);
    step();
    check("single_cnt0", {13'd0, fifo_count}, 16'd0);
    check("single_lo", {8'd0, tx_byte}, 16'h003C);
    check("single_lo_last", {15'd0, tx_last}, 16'd0);
    check("single_lo_oe", {15'd0, tx_oe}, 16'd1);
    step();
    check("single_hi", {8'd0, tx_byte}, 16'h004A);
    check("single_hi_last", {15'd0, tx_last}, 16'd1);
    step();
    check("single_idle", {15'd0, tx_valid}, 16'd0);
    check("single_oe0", {15'd0, tx_oe}, 16'd0);
    check("single_byte0", {8'd0, tx_byte}, 16'd0);

    // Streaming back-to-back
    exp_w[0] = 16'h1234; exp_w[1] = 16'hABCD; exp_w[2] = 16'h8001;
    res_data = exp_w[0]; res_valid = 1'b1;
    step();
    res_data = exp_w[1];
    step();
    check("stream_b0", {8'd0, tx_byte}, 16'h0034);
    res_data = exp_w[2];
    step();
    res_valid = 1'b0;
    check("stream_b1", {8'd0, tx_byte}, 16'h0012);
    check("stream_b1_last", {15'd0, tx_last}, 16'd1);
    step();
    exp_w[0] = 16'hABCD; exp_w[1] = 16'h8001;
    drain(2, "stream");

    // Backpressure in LO and HI
    tx_ready = 1'b0; res_data = 16'h5AA5; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_lo_byte", {8'd0, tx_byte}, 16'h00A5);
      check("bp_lo_last", {15'd0, tx_last}, 16'd0);
      check("bp_lo_valid", {15'd0, tx_valid}, 16'd1);
      step();
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hi_byte", {8'd0, tx_byte}, 16'h005A);
      check("bp_hi_last", {15'd0, tx_last}, 16'd1);
      check("bp_hi_valid", {15'd0, tx_valid}, 16'd1);
      step();
    end
    tx_ready = 1'b1;
    step();
    check("bp_idle", {15'd0, tx_valid}, 16'd0);

    // Full and overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      res_data = 16'h1100 + 16'(i); res_valid = 1'b1;
      step();
    end
    res_valid = 1'b0;
    check("full_cnt", {13'd0, fifo_count}, 16'd4);
    check("full_ready", {15'd0, res_ready}, 16'd0);
    check("full_ovf", {15'd0, overflow}, 16'd1);
    check("full_hold", {8'd0, tx_byte}, 16'h0000);
    ovf_clr = 1'b1; res_valid = 1'b1; res_data = 16'hDEAD;
    step();
    res_valid = 1'b0;
    check("ovf_set_wins", {15'd0, overflow}, 16'd1);
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", {15'd0, overflow}, 16'd0);
    for (int i = 0; i < 5; i++) exp_w[i] = 16'h1100 + 16'(i);
    drain(5, "full_drain");

    // Push and pop together at count 3
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res_data = 16'hA000 + 16'(i); res_valid = 1'b1;
      step();
    end
    res_valid = 1'b0;
    check("pp_cnt3", {13'd0, fifo_count}, 16'd3);
    tx_ready = 1'b1;
    step();
    check("pp_hi", {8'd0, tx_byte}, 16'h00A0);
    res_data = 16'hA004; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("pp_cnt_same", {13'd0, fifo_count}, 16'd3);
    for (int i = 0; i < 4; i++) exp_w[i] = 16'hA001 + 16'(i);
    drain(4, "pp_drain");

    // Reset mid-transfer
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_data = 16'hB000 + 16'(i); res_valid = 1'b1;
      step();
    end
    res_valid = 1'b0;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("rm_in_hi", {15'd0, tx_last}, 16'd1);
    check("rm_cnt2", {13'd0, fifo_count}, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rm_valid", {15'd0, tx_valid}, 16'd0);
    check("rm_cnt", {13'd0, fifo_count}, 16'd0);
    check("rm_oe", {15'd0, tx_oe}, 16'd0);
    #1 rst_n = 1'b1;
    res_data = 16'h00FF; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    exp_w[0] = 16'h00FF;
    drain(1, "rm_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
